srm_control_fsm: RTL

- Moore control state machine for the Simple RISC Machine CPU.
- Consumes opcode/op from the instruction decoder and drives its nsel select.
- Drives all datapath, program-counter, instruction-register and memory strobes.
- Sequences fetch, decode, execute and writeback, one state per datapath step.

---
 rtl/srm_pkg.sv | 71 +++++++
 rtl/srm_wait_counter.sv | 39 +++
 rtl/srm_control_fsm.sv | 263 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/srm_pkg.sv
// -----------------------------------------------------------------------------
// srm_pkg
// Shared definitions for the Simple RISC Machine control path.
//   - Instruction opcode/op field codes (bits [15:13] and [12:11]).
//   - Register-select (nsel), writeback-select (vsel) and memory command codes.
//   - Controller state enumeration.
// Optional build macro: SRM_IRQ_EN adds the interrupt entry states.
// -----------------------------------------------------------------------------
package srm_pkg;

    // Opcode field, instruction bits [15:13]
    localparam logic [2:0] OPC_MOV = 3'b110;
    localparam logic [2:0] OPC_ALU = 3'b101;
    localparam logic [2:0] OPC_LDR = 3'b011;
    localparam logic [2:0] OPC_STR = 3'b100;
    localparam logic [2:0] OPC_HLT = 3'b111;

    // Op field, instruction bits [12:11]
    localparam logic [1:0] OP_MOV_IMM = 2'b10;
    localparam logic [1:0] OP_MOV_REG = 2'b00;
    localparam logic [1:0] OP_CMP     = 2'b01;
    localparam logic [1:0] OP_MEM     = 2'b00;

    // Register file read/write select
    localparam logic [1:0] NSEL_RN = 2'b00;
    localparam logic [1:0] NSEL_RD = 2'b01;
    localparam logic [1:0] NSEL_RM = 2'b10;
    localparam logic [1:0] NSEL_R6 = 2'b11;

    // Writeback mux select
    localparam logic [1:0] VSEL_C     = 2'b00;
    localparam logic [1:0] VSEL_PC    = 2'b01;
    localparam logic [1:0] VSEL_IMM8  = 2'b10;
    localparam logic [1:0] VSEL_MDATA = 2'b11;

    // Memory command
    localparam logic [1:0] MEM_NONE  = 2'b00;
    localparam logic [1:0] MEM_READ  = 2'b01;
    localparam logic [1:0] MEM_WRITE = 2'b10;

    typedef enum logic [4:0] {
        S_RST,
        S_IF1,
        S_IF2,
        S_UPDATE_PC,
        S_DECODE,
        S_WR_IMM,
        S_GET_A,
        S_GET_B,
        S_EXEC,
        S_WR_REG,
        S_ADDR,
        S_LD_ADDR,
        S_GET_D,
        S_PASS_D,
        S_MEM_WR,
        S_MEM_RD,
        S_LDR_WB,
`ifdef SRM_IRQ_EN
        S_IRQ_SAVE,
        S_IRQ_VEC,
`endif
        S_HALT
    } state_t;

    // States that hold for the programmed number of memory wait cycles.
    function automatic logic is_wait_state(input state_t s);
        return s inside {S_IF1, S_MEM_RD, S_MEM_WR};
    endfunction

endpackage : srm_pkg

// File: rtl/srm_wait_counter.sv
// -----------------------------------------------------------------------------
// srm_wait_counter
// Loadable 4-bit down-counter that measures memory wait cycles. The count is
// loaded when the controller enters a wait state and steps down once per cycle
// while the controller remains there; o_done is high when the count is zero.
// Ports:
//   clk        in   system clock, rising edge
//   reset      in   synchronous, active-high; clears the count
//   i_load     in   load i_load_val (takes priority over decrement)
//   i_load_val in   4-bit value to load
//   i_dec      in   decrement enable; saturates at zero
//   o_done     out  count is zero
// -----------------------------------------------------------------------------
module srm_wait_counter (
    input  logic       clk,
    input  logic       reset,
    input  logic       i_load,
    input  logic [3:0] i_load_val,
    input  logic       i_dec,
    output logic       o_done
);

    logic [3:0] r_count;

    // NOTE: sequential state is always assigned with <= so every flop samples
    // its inputs from before the edge, independent of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_count <= 4'd0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (i_dec && (r_count != 4'd0)) begin
            r_count <= r_count - 4'd1;
        end
    end

    assign o_done = (r_count == 4'd0);

endmodule : srm_wait_counter

// File: rtl/srm_control_fsm.sv
// -----------------------------------------------------------------------------
// srm_control_fsm
// Moore control state machine for the Simple RISC Machine CPU. Sequences
// fetch, decode, execute and writeback, one state per datapath step, and
// drives every datapath, PC, IR and memory strobe from the state register.
// The instruction class is captured in DECODE so that the execute-phase
// strobes depend only on registered state, never directly on the inputs.
//
// Parameter:
//   WAIT_CYCLES  extra memory wait cycles held in IF1, MEM_RD and MEM_WR (0..15)
//
// Build macro:
//   SRM_IRQ_EN   adds the irq input and the IRQ_SAVE / IRQ_VEC entry states.
//
// Ports:
//   clk        in   system clock, rising edge
//   reset      in   synchronous, active-high
//   irq        in   level interrupt request (SRM_IRQ_EN only)
//   opcode     in   instruction bits [15:13]
//   op         in   instruction bits [12:11]
//   nsel       out  register select: 00 Rn, 01 Rd, 10 Rm, 11 R6
//   vsel       out  writeback mux: 00 C, 01 PC, 10 sximm8, 11 mdata
//   loada/b/c/s out datapath register enables
//   asel       out  A input forced to zero
//   bsel       out  B input takes sximm5
//   write      out  register file write enable
//   load_ir, load_pc, reset_pc, addr_sel, load_addr  out  fetch/address control
//   mem_cmd    out  00 NONE, 01 READ, 10 WRITE
//   halted     out  high in HALT
// -----------------------------------------------------------------------------
module srm_control_fsm
    import srm_pkg::*;
#(
    parameter int unsigned WAIT_CYCLES = 0
) (
    input  logic       clk,
    input  logic       reset,
`ifdef SRM_IRQ_EN
    input  logic       irq,
`endif
    input  logic [2:0] opcode,
    input  logic [1:0] op,
    output logic [1:0] nsel,
    output logic [1:0] vsel,
    output logic       loada,
    output logic       loadb,
    output logic       loadc,
    output logic       loads,
    output logic       asel,
    output logic       bsel,
    output logic       write,
    output logic       load_ir,
    output logic       load_pc,
    output logic       reset_pc,
    output logic       addr_sel,
    output logic       load_addr,
    output logic [1:0] mem_cmd,
    output logic       halted
);

    localparam logic [3:0] WAIT_LOAD = 4'(WAIT_CYCLES);

    state_t     r_state;
    state_t     w_next;
    logic [2:0] r_opcode;
    logic [1:0] r_op;
    logic       w_cnt_load;
    logic       w_cnt_dec;
    logic       w_cnt_done;
    logic       w_is_cmp;

    // -------------------------------------------------------------------------
    // State register and instruction-class capture
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_RST;
        end else begin
            r_state <= w_next;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_opcode <= 3'b000;
            r_op     <= 2'b00;
        end else if (r_state == S_DECODE) begin
            r_opcode <= opcode;
            r_op     <= op;
        end
    end

    assign w_is_cmp = (r_opcode == OPC_ALU) && (r_op == OP_CMP);

    // -------------------------------------------------------------------------
    // Wait counter: reloaded whenever a wait state is entered (including a
    // wait state entered straight from another wait state, e.g. MEM_WR->IF1),
    // and counted down while the controller sits in one.
    // -------------------------------------------------------------------------
    assign w_cnt_load = (w_next != r_state) && is_wait_state(w_next);
    assign w_cnt_dec  = is_wait_state(r_state);

    srm_wait_counter u_wait_counter (
        .clk        (clk),
        .reset      (reset),
        .i_load     (w_cnt_load),
        .i_load_val (WAIT_LOAD),
        .i_dec      (w_cnt_dec),
        .o_done     (w_cnt_done)
    );

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: every always_comb target gets a default first so no path
        // through the case can leave it unassigned and infer a latch.
        w_next = r_state;
        case (r_state)
            S_RST:       w_next = S_IF1;
            S_IF1:       if (w_cnt_done) w_next = S_IF2;
            S_IF2:       w_next = S_UPDATE_PC;
`ifdef SRM_IRQ_EN
            S_UPDATE_PC: w_next = irq ? S_IRQ_SAVE : S_DECODE;
            S_IRQ_SAVE:  w_next = S_IRQ_VEC;
            S_IRQ_VEC:   w_next = S_IF1;
`else
            S_UPDATE_PC: w_next = S_DECODE;
`endif
            S_DECODE: begin
                if (opcode == OPC_MOV && op == OP_MOV_IMM) begin
                    w_next = S_WR_IMM;
                end else if (opcode == OPC_MOV && op == OP_MOV_REG) begin
                    w_next = S_GET_B;
                end else if (opcode == OPC_ALU) begin
                    w_next = S_GET_A;
                end else if ((opcode == OPC_LDR || opcode == OPC_STR) && op == OP_MEM) begin
                    w_next = S_GET_A;
                end else if (opcode == OPC_HLT) begin
                    w_next = S_HALT;
                end else begin
                    // Unrecognised encodings retire as a NOP.
                    w_next = S_IF1;
                end
            end
            S_WR_IMM:    w_next = S_IF1;
            // Only LDR/STR reach GET_A with these opcodes, so opcode alone
            // selects the address path.
            S_GET_A:     w_next = (r_opcode == OPC_LDR || r_opcode == OPC_STR) ? S_ADDR : S_GET_B;
            S_GET_B:     w_next = S_EXEC;
            S_EXEC:      w_next = w_is_cmp ? S_IF1 : S_WR_REG;
            S_WR_REG:    w_next = S_IF1;
            S_ADDR:      w_next = S_LD_ADDR;
            S_LD_ADDR:   w_next = (r_opcode == OPC_LDR) ? S_MEM_RD : S_GET_D;
            S_GET_D:     w_next = S_PASS_D;
            S_PASS_D:    w_next = S_MEM_WR;
            S_MEM_WR:    if (w_cnt_done) w_next = S_IF1;
            S_MEM_RD:    if (w_cnt_done) w_next = S_LDR_WB;
            S_LDR_WB:    w_next = S_IF1;
            S_HALT:      w_next = S_HALT;
            default:     w_next = S_RST;
        endcase
    end

    // -------------------------------------------------------------------------
    // Moore output decode
    // -------------------------------------------------------------------------
    always_comb begin
        nsel      = NSEL_RN;
        vsel      = VSEL_C;
        loada     = 1'b0;
        loadb     = 1'b0;
        loadc     = 1'b0;
        loads     = 1'b0;
        asel      = 1'b0;
        bsel      = 1'b0;
        write     = 1'b0;
        load_ir   = 1'b0;
        load_pc   = 1'b0;
        reset_pc  = 1'b0;
        addr_sel  = 1'b0;
        load_addr = 1'b0;
        mem_cmd   = MEM_NONE;
        halted    = 1'b0;
        case (r_state)
            S_RST: begin
                reset_pc = 1'b1;
                load_pc  = 1'b1;
            end
            S_IF1: begin
                addr_sel = 1'b1;
                mem_cmd  = MEM_READ;
            end
            S_IF2: begin
                addr_sel = 1'b1;
                mem_cmd  = MEM_READ;
                load_ir  = 1'b1;
            end
            S_UPDATE_PC: load_pc = 1'b1;
            S_WR_IMM: begin
                nsel  = NSEL_RN;
                vsel  = VSEL_IMM8;
                write = 1'b1;
            end
            S_GET_A: begin
                nsel  = NSEL_RN;
                loada = 1'b1;
            end
            S_GET_B: begin
                nsel  = NSEL_RM;
                loadb = 1'b1;
            end
            S_EXEC: begin
                // CMP updates only the status flags; MOV reg zeroes the A input
                // so C receives the (shifted) Rm value unchanged.
                loads = w_is_cmp;
                loadc = !w_is_cmp;
                asel  = (r_opcode == OPC_MOV);
            end
            S_WR_REG: begin
                nsel  = NSEL_RD;
                vsel  = VSEL_C;
                write = 1'b1;
            end
            S_ADDR: begin
                bsel  = 1'b1;
                loadc = 1'b1;
            end
            S_LD_ADDR: load_addr = 1'b1;
            S_GET_D: begin
                nsel  = NSEL_RD;
                loadb = 1'b1;
            end
            S_PASS_D: begin
                asel  = 1'b1;
                loadc = 1'b1;
            end
            S_MEM_WR: mem_cmd = MEM_WRITE;
            S_MEM_RD: mem_cmd = MEM_READ;
            S_LDR_WB: begin
                mem_cmd = MEM_READ;
                nsel    = NSEL_RD;
                vsel    = VSEL_MDATA;
                write   = 1'b1;
            end
`ifdef SRM_IRQ_EN
            S_IRQ_SAVE: begin
                // Return address (already-incremented PC) goes to R6.
                nsel  = NSEL_R6;
                vsel  = VSEL_PC;
                write = 1'b1;
            end
            S_IRQ_VEC: begin
                reset_pc = 1'b1;
                load_pc  = 1'b1;
            end
`endif
            S_HALT: halted = 1'b1;
            default: ;
        endcase
    end

endmodule : srm_control_fsm
